// File: rtl/wb_burst_ram.sv
// wb_burst_ram: single-port Wishbone B3 data RAM with byte lanes, programmable
// first-beat wait states and registered-feedback incrementing bursts (CTI/BTE).
//
// Ports:
//   CLK, RST_ASYNC_N      clock (rising edge), asynchronous active-low reset
//   RAM_CYC_IN/STB_IN     Wishbone cycle / strobe
//   RAM_ADR_IN            byte address; bits above ADDR_WIDTH-1 flag an ERR
//   RAM_SEL_IN            byte-lane selects
//   RAM_WE_IN             write enable
//   RAM_CTI_IN            010 incrementing burst, 111 end-of-burst, else classic
//   RAM_BTE_IN            00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   RAM_DAT_WR_IN         write data
//   RAM_ACK_OUT           acknowledge (registered)
//   RAM_ERR_OUT           error, address out of range (registered)
//   RAM_DAT_RD_OUT        read data, valid while ACK is high
module wb_burst_ram #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    CLK,
    input  logic                    RST_ASYNC_N,
    input  logic                    RAM_CYC_IN,
    input  logic                    RAM_STB_IN,
    input  logic [31:0]             RAM_ADR_IN,
    input  logic [DATA_WIDTH/8-1:0] RAM_SEL_IN,
    input  logic                    RAM_WE_IN,
    input  logic [2:0]              RAM_CTI_IN,
    input  logic [1:0]              RAM_BTE_IN,
    input  logic [DATA_WIDTH-1:0]   RAM_DAT_WR_IN,
    output logic                    RAM_ACK_OUT,
    output logic                    RAM_ERR_OUT,
    output logic [DATA_WIDTH-1:0]   RAM_DAT_RD_OUT
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 0;
    localparam int unsigned IDX_BITS  = ADDR_WIDTH - OFF_BITS;
    localparam int unsigned DEPTH     = 2 ** IDX_BITS;

    typedef enum logic [1:0] {StIdle, StWait, StBurst, StTerm} state_e;

    state_e                r_state, w_state_d;
    logic [2:0]            r_cnt, w_cnt_d;
    logic [IDX_BITS-1:0]   r_nidx, w_nidx_d;
    logic                  r_ack, w_ack_d;
    logic                  r_err, w_err_d;
    logic [DATA_WIDTH-1:0] r_dat_rd;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req, w_oor, w_cti_inc;
    logic                  w_complete, w_beat;
    logic                  w_rd_en, w_wr_en;
    logic [IDX_BITS-1:0]   w_bus_idx, w_rd_idx;
    logic                  w_unused_adr;

    assign w_req        = RAM_CYC_IN & RAM_STB_IN;
    assign w_oor        = |RAM_ADR_IN[31:ADDR_WIDTH];
    assign w_bus_idx    = RAM_ADR_IN[ADDR_WIDTH-1:OFF_BITS];
    assign w_cti_inc    = (RAM_CTI_IN == 3'b010);
    // Sub-word address bits carry no meaning for a word-wide RAM.
    assign w_unused_adr = ^RAM_ADR_IN;

    // Next word of a burst: linear wraps modulo depth, wrapN stays inside its
    // aligned N-word block.
    function automatic logic [IDX_BITS-1:0] f_next_idx(input logic [IDX_BITS-1:0] idx,
                                                       input logic [1:0]          bte);
        logic [IDX_BITS-1:0] mask;
        logic [IDX_BITS-1:0] inc;
        case (bte)
            2'b01:   mask = IDX_BITS'(3);
            2'b10:   mask = IDX_BITS'(7);
            2'b11:   mask = IDX_BITS'(15);
            default: mask = '1;
        endcase
        inc = idx + IDX_BITS'(1);
        return (idx & ~mask) | (inc & mask);
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_nidx  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_nidx  <= w_nidx_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_complete = 1'b0;
        w_beat     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                if (!w_req) begin
                    w_state_d = StIdle;
                end else if (r_cnt == 3'd0) begin
                    w_complete = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 3'd1;
                end
            end
            StBurst: begin
                if (!w_req) begin
                    w_state_d = StIdle;
                end else if (w_oor) begin
                    w_state_d = StTerm;
                end else begin
                    w_beat = 1'b1;
                    // Anything other than an incrementing beat closes the burst.
                    if (!w_cti_inc) begin
                        w_state_d = StIdle;
                    end
                end
            end
            StTerm: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (w_complete) begin
            w_state_d = (!w_oor && w_cti_inc) ? StBurst : StTerm;
        end
    end

    // Output / datapath control
    always_comb begin
        w_ack_d  = 1'b0;
        w_err_d  = 1'b0;
        w_rd_en  = 1'b0;
        w_wr_en  = 1'b0;
        w_rd_idx = w_bus_idx;
        w_nidx_d = r_nidx;
        if (w_complete) begin
            if (w_oor) begin
                w_err_d = 1'b1;
            end else begin
                w_ack_d  = 1'b1;
                w_rd_en  = 1'b1;
                w_wr_en  = RAM_WE_IN;
                w_nidx_d = f_next_idx(w_bus_idx, RAM_BTE_IN);
            end
        end else if (w_beat) begin
            w_wr_en = RAM_WE_IN;
            if (w_cti_inc) begin
                // Prefetch the following beat from the internal burst address.
                w_ack_d  = 1'b1;
                w_rd_en  = 1'b1;
                w_rd_idx = r_nidx;
                w_nidx_d = f_next_idx(r_nidx, RAM_BTE_IN);
            end
        end else if (r_state == StBurst && w_req && w_oor) begin
            w_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat_rd <= '0;
        end else begin
            r_ack <= w_ack_d;
            r_err <= w_err_d;
            // Read-first: a same-word write returns the old contents.
            if (w_rd_en) begin
                r_dat_rd <= r_mem[w_rd_idx];
            end
        end
    end

    // Memory array is not reset.
    always_ff @(posedge CLK) begin
        if (RST_ASYNC_N && w_wr_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (RAM_SEL_IN[i]) begin
                    r_mem[w_bus_idx][8*i +: 8] <= RAM_DAT_WR_IN[8*i +: 8];
                end
            end
        end
    end

    assign RAM_ACK_OUT    = r_ack;
    assign RAM_ERR_OUT    = r_err;
    assign RAM_DAT_RD_OUT = r_dat_rd;
endmodule

// File: tb/tb_wb_burst_ram.sv
// Self-checking bench for wb_burst_ram: a zero-wait instance checked through a
// response scoreboard, plus a WAIT_STATES=3 instance checked for latency.
module tb_wb_burst_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, cyc3 = 1'b0, stb3 = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dwr = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        ack, err, ack3, err3;
    logic [31:0] drd, drd3;

    always #5 clk = ~clk;

    wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RST_ASYNC_N(rst_n), .RAM_CYC_IN(cyc), .RAM_STB_IN(stb),
        .RAM_ADR_IN(adr), .RAM_SEL_IN(sel), .RAM_WE_IN(we), .RAM_CTI_IN(cti),
        .RAM_BTE_IN(bte), .RAM_DAT_WR_IN(dwr), .RAM_ACK_OUT(ack), .RAM_ERR_OUT(err),
        .RAM_DAT_RD_OUT(drd)
    );

    wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .CLK(clk), .RST_ASYNC_N(rst_n), .RAM_CYC_IN(cyc3), .RAM_STB_IN(stb3),
        .RAM_ADR_IN(adr), .RAM_SEL_IN(sel), .RAM_WE_IN(we), .RAM_CTI_IN(cti),
        .RAM_BTE_IN(bte), .RAM_DAT_WR_IN(dwr), .RAM_ACK_OUT(ack3), .RAM_ERR_OUT(err3),
        .RAM_DAT_RD_OUT(drd3)
    );

    typedef struct {
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tag_ctr = 0;

    logic [31:0] e_lin [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] e_wr4 [8] = '{32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response presented to an active strobe consumes one entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && cyc && stb && (ack || err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {30'd0, ack, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("resp%0d_ackerr", e.tag), {30'd0, ack, err},
                      {30'd0, !e.exp_err, e.exp_err});
                if (e.chk_dat) check($sformatf("resp%0d_data", e.tag), drd, e.exp_dat);
            end
        end
    end

    function automatic int nxt(input int i, input logic [1:0] b);
        int mask;
        mask = (b == 2'b00) ? 1023 : (b == 2'b01) ? 3 : (b == 2'b10) ? 7 : 15;
        return (i & ~mask) | ((i + 1) & mask);
    endfunction

    task automatic drive(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
        we = w; adr = a; sel = s; dwr = d; cti = c; bte = b;
    endtask

    task automatic wait_resp(input bit on3, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (on3 ? (ack3 | err3) : (ack | err)) ok = 1'b1;
        end
        if (!ok) check("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic classic(input string name, input bit on3, input bit w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d, input bit eerr,
                           input bit chk, input logic [31:0] edat);
        int n;
        bit ok;
        if (!on3) begin
            sb_q.push_back('{exp_err: eerr, chk_dat: chk, exp_dat: edat, tag: tag_ctr});
            tag_ctr++;
        end
        @(posedge clk); #1;
        drive(w, a, s, d, 3'b000, 2'b00);
        if (on3) begin cyc3 = 1'b1; stb3 = 1'b1; end
        else begin cyc = 1'b1; stb = 1'b1; end
        wait_resp(on3, n, ok);
        if (ok) begin
            check({name, "_lat"}, 32'(n), on3 ? 32'd5 : 32'd2);
            if (on3 && chk) check({name, "_data"}, drd3, edat);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
        @(negedge clk);
        check({name, "_pulse"}, on3 ? {30'd0, ack3, err3} : {30'd0, ack, err}, 32'd0);
    endtask

    // Registered-feedback burst master: advances to the next beat after each ACK.
    task automatic burst(input string name, input bit w, input int start, input logic [1:0] b,
                         input int nbeats, input int stop_after, input logic [31:0] dbase,
                         input logic [31:0] ed [8]);
        int idx;
        int n;
        bit ok;
        idx = start;
        for (int k = 0; k < stop_after; k++) begin
            sb_q.push_back('{exp_err: 1'b0, chk_dat: !w, exp_dat: ed[k], tag: tag_ctr});
            tag_ctr++;
        end
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1;
        drive(w, 32'(idx * 4), 4'hF, dbase, (nbeats == 1) ? 3'b111 : 3'b010, b);
        for (int k = 0; k < stop_after; k++) begin
            wait_resp(1'b0, n, ok);
            if (!ok) break;
            check($sformatf("%s_beat%0d_lat", name, k), 32'(n), (k == 0) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            if (k + 1 < stop_after) begin
                idx = nxt(idx, b);
                drive(w, 32'(idx * 4), 4'hF, dbase + 32'(k + 1),
                      (k + 1 == nbeats - 1) ? 3'b111 : 3'b010, b);
            end else begin
                cyc = 1'b0; stb = 1'b0;
            end
        end
        // An abort leaves one stale ACK cycle before the slave sees STB low.
        if (stop_after < nbeats) @(negedge clk);
        @(negedge clk);
        check({name, "_end"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  ok;
        bit  saw;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dat", drd, 32'd0);
        rst_n = 1'b1;

        // Classic write/read, byte lane merge with read-first return
        classic("wr10", 0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0);
        classic("rd10", 0, 0, 32'h10, 4'h2, 32'h0, 0, 1, 32'hDEADBEEF);
        classic("wrb10", 0, 1, 32'h10, 4'h1, 32'h000000AA, 0, 1, 32'hDEADBEEF);
        classic("rdb10", 0, 0, 32'h10, 4'hF, 32'h0, 0, 1, 32'hDEADBEAA);

        // Words 0..7 hold their index; word 10 holds 0x55
        for (int i = 0; i < 8; i++) classic("fill", 0, 1, 32'(i * 4), 4'hF, 32'(i), 0, 0, 32'h0);
        classic("fill10", 0, 1, 32'h28, 4'hF, 32'h55, 0, 0, 32'h0);

        burst("lin8", 0, 0, 2'b00, 8, 8, 32'h0, e_lin);
        burst("wrap4", 0, 2, 2'b01, 4, 4, 32'h0, e_wr4);

        // Burst write aborted after two beats
        burst("bwab", 1, 8, 2'b00, 8, 2, 32'hA0, e_lin);
        classic("rd8", 0, 0, 32'h20, 4'hF, 32'h0, 0, 1, 32'hA0);
        classic("rd9", 0, 0, 32'h24, 4'hF, 32'h0, 0, 1, 32'hA1);
        classic("rd10w", 0, 0, 32'h28, 4'hF, 32'h0, 0, 1, 32'h55);

        // Out-of-range write must not alias onto word 0
        classic("oor", 0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1, 0, 32'h0);
        classic("rd0", 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 32'h0);

        // Asynchronous reset in the middle of a linear read burst
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{exp_err: 1'b0, chk_dat: 1'b1, exp_dat: 32'(k), tag: tag_ctr});
            tag_ctr++;
        end
        @(posedge clk); #1;
        drive(0, 32'h0, 4'hF, 32'h0, 3'b010, 2'b00);
        cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_resp(1'b0, n, ok);
            @(posedge clk); #1;
            drive(0, 32'((k + 1) * 4), 4'hF, 32'h0, 3'b010, 2'b00);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", {31'd0, ack}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_dat", drd, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        check("arst_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        classic("post_rst", 0, 0, 32'h14, 4'hF, 32'h0, 0, 1, 32'h5);

        // WAIT_STATES=3 instance: 4-cycle first-beat latency and early STB drop
        classic("w3_wr", 1, 1, 32'h20, 4'hF, 32'h12345678, 0, 0, 32'h0);
        classic("w3_rd", 1, 0, 32'h20, 4'hF, 32'h0, 0, 1, 32'h12345678);
        @(posedge clk); #1;
        drive(1, 32'h20, 4'hF, 32'hFFFFFFFF, 3'b000, 2'b00);
        cyc3 = 1'b1; stb3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 cyc3 = 1'b0; stb3 = 1'b0;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack3 || err3) saw = 1'b1;
        end
        check("w3_drop_noack", {31'd0, saw}, 32'd0);
        classic("w3_rd2", 1, 0, 32'h20, 4'hF, 32'h0, 0, 1, 32'h12345678);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_burst_ram.md
Name: wb_burst_ram

Overview:
- Parametrised single-port Wishbone B3 data RAM. Next generation of the core's data memory.
- Adds configurable data width and depth, programmable first-beat wait states, and registered-feedback incrementing bursts (CTI/BTE).
- Adds an ERR response for out-of-range addresses.
- Sits on the core data bus as a slave. Inferred as byte-lane, read-first block RAM.

Parameters:
- DATA_WIDTH, 32: bus and word width in bits; must be a multiple of 8 (8..128).
- ADDR_WIDTH, 12: byte-address bits decoded; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words.
- WAIT_STATES, 0: extra cycles (0..7) inserted before the first ACK/ERR of each access.

Ports:
- CLK  in  1  clock, rising edge.
- RST_ASYNC_N  in  1  asynchronous active-low reset.
- RAM_CYC_IN  in  1  Wishbone cycle.
- RAM_STB_IN  in  1  Wishbone strobe.
- RAM_ADR_IN  in  32  byte address.
- RAM_SEL_IN  in  DATA_WIDTH/8  byte-lane selects.
- RAM_WE_IN  in  1  write enable.
- RAM_CTI_IN  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; others treated as 000.
- RAM_BTE_IN  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- RAM_DAT_WR_IN  in  DATA_WIDTH  write data.
- RAM_ACK_OUT  out  1  acknowledge.
- RAM_ERR_OUT  out  1  error, address out of range.
- RAM_DAT_RD_OUT  out  DATA_WIDTH  read data, valid while ACK is high.

Behaviour:
- Reset (asynchronous, immediate):
  - ACK=0, ERR=0, DAT_RD_OUT=0; FSM to IDLE; wait counter and burst address cleared.
  - RAM contents are not reset.
  - Reset mid-access drops ACK/ERR at once. The master must restart the access.
- Address decode:
  - Word index = ADR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
  - Out of range = any bit of ADR[31:ADDR_WIDTH] set. Index bits below the word boundary are ignored.
- FSM states: IDLE, WAIT, BURST, TERM.
- IDLE:
  - CYC&STB sampled high at edge N with WAIT_STATES=0: the access completes at edge N.
  - With WAIT_STATES=W>0: go to WAIT, counter loaded with W-1.
- WAIT:
  - Counter decrements per cycle.
  - When it reaches 0 and CYC&STB is still high, the access completes at that edge.
  - CYC or STB low in WAIT: return to IDLE, no write, no ACK.
- Access completion edge:
  - In range: write lanes where WE&SEL[i] from the bus ADR/DAT; read the whole word (read-first, so DAT_RD returns old data on a same-word write); assert ACK next cycle.
  - Out of range: no write, DAT_RD holds, assert ERR next cycle.
  - ACK/ERR-then-next-state by CTI:
    - CTI=010 and in range: ACK with next state BURST.
    - CTI other and in range: ACK with next state TERM.
    - Out of range (any CTI): ERR with next state TERM.
- First-beat latency: 1+WAIT_STATES cycles from STB sampled to ACK/ERR.
- BURST (ACK high each cycle, one beat per cycle, zero wait):
  - At every edge with CYC&STB high, the current beat is accepted; writes use the bus ADR/DAT/SEL of that beat.
  - Read data for the next beat is fetched from an internal next address = current word index +1, wrapped per BTE. Linear wraps modulo depth; wrapN wraps within the aligned N-word block.
  - If CTI of the accepted beat is 111: ACK deasserts the next cycle and the FSM goes to IDLE.
  - If a beat's bus ADR is out of range: ERR replaces ACK for that beat, no write, go to TERM.
  - STB low at an edge: abort; ACK low next cycle, no write, go to IDLE. A later access pays full first-beat latency.
- TERM: ACK/ERR is high for exactly one cycle, then the FSM goes to IDLE. STB is not re-sampled in TERM, so back-to-back classic accesses have a minimum spacing of 2 cycles.
- ACK and ERR are never high together. Both are registered; no combinational path from inputs to outputs.

Test Plan:
- Classic write 0xDEADBEEF to 0x10 with SEL=1111, then read 0x10 with SEL=0010, WAIT_STATES=0 -> ACK one cycle after STB each time; read returns 0xDEADBEEF; pulses 1 cycle.
- Byte-lane write of 0x000000AA with SEL=0001 over 0xDEADBEEF, then read -> 0xDEADBEAA; same-cycle read-during-write returns the old word.
- WAIT_STATES=3, read 0x20 -> ACK exactly 4 cycles after STB sampled. Dropping STB after 2 cycles -> no ACK, no write.
- Linear burst read of 8 words from 0x0 (CTI=010 ×7, then 111), after writes of value = index -> ACK high 8 consecutive cycles, data 0..7, then ACK low.
- Wrap4 burst starting at word 2 -> data order words 2,3,0,1. Burst write with STB dropped after beat 2 -> only 2 words written, ACK low next cycle.
- ADR=0x0000_1000 (ADDR_WIDTH=12) -> ERR one cycle later, memory unchanged. Assert RST_ASYNC_N low mid-burst -> ACK/ERR/DAT_RD go 0 asynchronously; next access behaves as from IDLE.
